mem_access_stage: RTL and testbench

//  MEM stage of the 5-stage PCPU; sits directly downstream of the EX/MEM pipeline register.

---
 rtl/mem_access_stage.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access, byte-lane steering, load extend, MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses on the extra misalign_o output.
module mem_access_stage #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWrite_i,
   input  logic        RegData_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [5:0]  Op_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] Data_i,
   input  logic [4:0]  Rd_i,
   output logic        stall_o,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        RegWrite_o,
   output logic [31:0] WriteData_o,
   output logic [4:0]  Rd_o,
`ifdef MISALIGN_TRAP_EN
   output logic        misalign_o,
`endif
   output logic        bus_err_o
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam int unsigned CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT - 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [29:0]   addr_q, addr_d;
   logic [1:0]    alo_q, alo_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [5:0]    op_q, op_d;
   logic [4:0]    rd_q, rd_d;
   logic          rw_q, rw_d;
   logic          rsel_q, rsel_d;
   logic          rwo_q, rwo_d;
   logic [31:0]   wbo_q, wbo_d;
   logic [4:0]    rdo_q, rdo_d;
   logic          err_q, err_d;
`ifdef MISALIGN_TRAP_EN
   logic          mis_q, mis_d;
`endif

   logic          access;
   logic          is_load;
   logic          misal;
   logic          in_idle;
   logic          in_wait;
   logic          timeout;
   logic [3:0]    be_st;
   logic [31:0]   wd_st;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic [31:0]   ld_fmt;

   assign access  = MemRead_i | MemWrite_i;
   assign is_load = MemRead_i;
   assign in_idle = (state_q == S_IDLE);
   assign in_wait = (state_q == S_WAIT);
   assign timeout = in_wait & ~mem_ack & (cnt_q == CNT_MAX);

`ifdef MISALIGN_TRAP_EN
   assign misal =
      (((Op_i == OP_LH) || (Op_i == OP_LHU) || (Op_i == OP_SH))
         && ALUResult_i[0])
      || (((Op_i == OP_LW) || (Op_i == OP_SW))
         && (ALUResult_i[1:0] != 2'b00));
   assign misalign_o = mis_q;
`else
   assign misal = 1'b0;
`endif

   assign stall_o = (in_idle & access & ~misal)
                  | (in_wait & ~mem_ack & ~timeout);

   assign mem_req     = req_q;
   assign mem_we      = we_q;
   assign mem_addr    = {addr_q, 2'b00};
   assign mem_be      = be_q;
   assign mem_wdata   = wdata_q;
   assign RegWrite_o  = rwo_q;
   assign WriteData_o = wbo_q;
   assign Rd_o        = rdo_q;
   assign bus_err_o   = err_q;

   // Loads always fetch the full word; sub-word stores steer into lanes.
   always_comb begin
      be_st = 4'b1111;
      wd_st = Data_i;
      if (!is_load) begin
         unique case (1'b1)
            Op_i == OP_SB: begin
               be_st = 4'b0001 << ALUResult_i[1:0];
               wd_st = {4{Data_i[7:0]}};
            end
            Op_i == OP_SH: begin
               be_st = ALUResult_i[1] ? 4'b1100 : 4'b0011;
               wd_st = {2{Data_i[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      unique case (alo_q)
         2'd0:    byte_v = mem_rdata[7:0];
         2'd1:    byte_v = mem_rdata[15:8];
         2'd2:    byte_v = mem_rdata[23:16];
         default: byte_v = mem_rdata[31:24];
      endcase
      half_v = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      ld_fmt = mem_rdata;
      unique case (1'b1)
         op_q == OP_LB:  ld_fmt = {{24{byte_v[7]}}, byte_v};
         op_q == OP_LBU: ld_fmt = {24'b0, byte_v};
         op_q == OP_LH:  ld_fmt = {{16{half_v[15]}}, half_v};
         op_q == OP_LHU: ld_fmt = {16'b0, half_v};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         alo_q   <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         rw_q    <= 1'b0;
         rsel_q  <= 1'b0;
         rwo_q   <= 1'b0;
         wbo_q   <= '0;
         rdo_q   <= '0;
         err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         alo_q   <= alo_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         rw_q    <= rw_d;
         rsel_q  <= rsel_d;
         rwo_q   <= rwo_d;
         wbo_q   <= wbo_d;
         rdo_q   <= rdo_d;
         err_q   <= err_d;
`ifdef MISALIGN_TRAP_EN
         mis_q   <= mis_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (access && !misal) state_d = S_WAIT;
         S_WAIT: if (mem_ack || timeout) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      alo_d   = alo_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      op_d    = op_q;
      rd_d    = rd_q;
      rw_d    = rw_q;
      rsel_d  = rsel_q;
      rwo_d   = 1'b0;
      wbo_d   = wbo_q;
      rdo_d   = rdo_q;
      err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!access) begin
               rwo_d = RegWrite_i;
               wbo_d = ALUResult_i;
               rdo_d = Rd_i;
            end else if (misal) begin
`ifdef MISALIGN_TRAP_EN
               mis_d = 1'b1;
`endif
            end else begin
               req_d   = 1'b1;
               we_d    = ~is_load;
               addr_d  = ALUResult_i[31:2];
               alo_d   = ALUResult_i[1:0];
               be_d    = be_st;
               wdata_d = wd_st;
               op_d    = Op_i;
               rd_d    = Rd_i;
               rw_d    = RegWrite_i;
               rsel_d  = RegData_i;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               req_d = 1'b0;
               cnt_d = '0;
               rwo_d = rw_q;
               wbo_d = rsel_q ? ld_fmt : {addr_q, alo_q};
               rdo_d = rd_q;
            end else if (timeout) begin
               req_d = 1'b0;
               cnt_d = '0;
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus randomized loads/stores
// checked against a transaction-level model of lanes, extension and ack timing.
module tb_mem_access_stage;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWrite_i, RegData_i, MemRead_i, MemWrite_i;
   logic [5:0]  Op_i;
   logic [31:0] ALUResult_i, Data_i;
   logic [4:0]  Rd_i;
   logic        stall_o, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        RegWrite_o;
   logic [31:0] WriteData_o;
   logic [4:0]  Rd_o;
   logic        bus_err_o;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.ACK_TIMEOUT(TMO)) dut (
      .clk(clk),
      .rst(rst),
      .RegWrite_i(RegWrite_i),
      .RegData_i(RegData_i),
      .MemRead_i(MemRead_i),
      .MemWrite_i(MemWrite_i),
      .Op_i(Op_i),
      .ALUResult_i(ALUResult_i),
      .Data_i(Data_i),
      .Rd_i(Rd_i),
      .stall_o(stall_o),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_be(mem_be),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ack(mem_ack),
      .RegWrite_o(RegWrite_o),
      .WriteData_o(WriteData_o),
      .Rd_o(Rd_o),
`ifdef MISALIGN_TRAP_EN
      .misalign_o(misalign_o),
`endif
      .bus_err_o(bus_err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] m_be(input logic [5:0] op,
                                       input logic ld, input logic [31:0] a);
      if (ld) return 4'hF;
      if (op == 6'h28) return 4'(1 << (a % 4));
      if (op == 6'h29) return (((a / 2) % 2) == 1) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wd(input logic [5:0] op,
                                        input logic [31:0] d);
      if (op == 6'h28) return (d % 256) * 32'h0101_0101;
      if (op == 6'h29) return (d % 65536) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_ld(input logic [5:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] r);
      logic [31:0] v;
      case (op)
         6'h20, 6'h24: begin
            v = (r >> (8 * (a % 4))) % 256;
            if (op == 6'h20) v = (v ^ 32'h80) - 32'h80;
         end
         6'h21, 6'h25: begin
            v = (r >> (16 * ((a / 2) % 2))) % 65536;
            if (op == 6'h21) v = (v ^ 32'h8000) - 32'h8000;
         end
         default: v = r;
      endcase
      return v;
   endfunction

`ifdef MISALIGN_TRAP_EN
   function automatic bit m_mis(input logic [5:0] op, input logic [31:0] a);
      if ((op == 6'h21 || op == 6'h25 || op == 6'h29) && (a % 2) != 0)
         return 1'b1;
      if ((op == 6'h23 || op == 6'h2B) && (a % 4) != 0)
         return 1'b1;
      return 1'b0;
   endfunction
`endif

   task automatic drive_nop(input logic rw, input logic [31:0] v,
                            input logic [4:0] rd);
      MemRead_i   = 1'b0;
      MemWrite_i  = 1'b0;
      Op_i        = 6'h00;
      RegWrite_i  = rw;
      RegData_i   = 1'b0;
      ALUResult_i = v;
      Data_i      = $urandom;
      Rd_i        = rd;
   endtask

   task automatic do_nop(input logic rw, input logic [31:0] v,
                         input logic [4:0] rd);
      drive_nop(rw, v, rd);
      #1;
      chk("nop_stall", stall_o, 0);
      tick;
      chk("nop_rw", RegWrite_o, rw);
      chk("nop_data", WriteData_o, v);
      chk("nop_rd", Rd_o, rd);
   endtask

   // dly = WAIT cycle in which ack arrives; dly > TMO means never.
   task automatic do_mem(input logic [5:0] op, input logic rd_en,
                         input logic wr_en, input logic rw, input logic rsel,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input int dly,
                         input logic [31:0] rdata);
      logic [31:0] wb;
      MemRead_i   = rd_en;
      MemWrite_i  = wr_en;
      Op_i        = op;
      RegWrite_i  = rw;
      RegData_i   = rsel;
      ALUResult_i = a;
      Data_i      = d;
      Rd_i        = rd;
      #1;
`ifdef MISALIGN_TRAP_EN
      if (m_mis(op, a)) begin
         chk("mis_stall", stall_o, 0);
         tick;
         chk("mis_req", mem_req, 0);
         chk("mis_pulse", misalign_o, 1);
         chk("mis_rw", RegWrite_o, 0);
         drive_nop(1'b0, 32'h0, 5'd0);
         tick;
         chk("mis_clear", misalign_o, 0);
         return;
      end
`endif
      chk("req_stall", stall_o, 1);
      tick;
      chk("req", mem_req, 1);
      chk("we", mem_we, !rd_en);
      chk("addr", mem_addr, a & ~32'd3);
      chk("be", mem_be, m_be(op, rd_en, a));
      if (!rd_en) chk("wdata", mem_wdata, m_wd(op, d));
      chk("bubble0", RegWrite_o, 0);
      for (int k = 1; k <= TMO; k++) begin
         if (k == dly) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
            #1;
            chk("ack_stall", stall_o, 0);
            tick;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            wb = rsel ? m_ld(op, a, rdata) : a;
            chk("req_drop", mem_req, 0);
            chk("wb_rw", RegWrite_o, rw);
            chk("wb_data", WriteData_o, wb);
            chk("wb_rd", Rd_o, rd);
            chk("wb_err", bus_err_o, 0);
            return;
         end
         if (k == TMO) begin
            chk("tmo_stall", stall_o, 0);
            tick;
            chk("tmo_err", bus_err_o, 1);
            chk("tmo_req", mem_req, 0);
            chk("tmo_rw", RegWrite_o, 0);
            drive_nop(1'b0, 32'h0, 5'd0);
            tick;
            chk("err_pulse", bus_err_o, 0);
            return;
         end
         chk("wait_stall", stall_o, 1);
         tick;
         chk("wait_req", mem_req, 1);
         chk("wait_bubble", RegWrite_o, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ops [9];
      ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F};
      rst       = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      drive_nop(1'b1, 32'hDEAD_BEEF, 5'd7);
      tick;
      tick;
      chk("rst_req", mem_req, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_rw", RegWrite_o, 0);
      chk("rst_data", WriteData_o, 0);
      chk("rst_rd", Rd_o, 0);
      chk("rst_err", bus_err_o, 0);
`ifdef MISALIGN_TRAP_EN
      chk("rst_mis", misalign_o, 0);
`endif
      rst = 1'b1;

      do_nop(1'b1, 32'h0000_1234, 5'd5);
      do_mem(6'h20, 1, 0, 1, 1, 32'h103, 32'h0, 5'd9, 3, 32'h80FF_0000);
      do_mem(6'h24, 1, 0, 1, 1, 32'h103, 32'h0, 5'd10, 3, 32'h80FF_0000);
      do_mem(6'h21, 1, 0, 1, 1, 32'h102, 32'h0, 5'd11, 1, 32'h8001_7FFF);
      do_mem(6'h25, 1, 0, 1, 1, 32'h100, 32'h0, 5'd12, 2, 32'h0001_F00D);
      do_mem(6'h29, 0, 1, 0, 0, 32'h102, 32'h0000_ABCD, 5'd0, 1, 32'h0);
      do_mem(6'h28, 0, 1, 0, 0, 32'h201, 32'h0000_005A, 5'd0, 2, 32'h0);
      do_mem(6'h2B, 0, 1, 0, 0, 32'h300, 32'h1122_3344, 5'd0, TMO + 1, 32'h0);
      do_mem(6'h23, 1, 0, 1, 1, 32'h400, 32'h0, 5'd13, TMO, 32'hCAFE_F00D);
      do_mem(6'h3F, 1, 1, 1, 0, 32'h0000_0ABC, 32'h0, 5'd14, 1, 32'h5555_AAAA);

      // Reset in the middle of a wait, then a stray ack.
      MemRead_i   = 1'b1;
      MemWrite_i  = 1'b0;
      Op_i        = 6'h23;
      RegWrite_i  = 1'b1;
      RegData_i   = 1'b1;
      ALUResult_i = 32'h200;
      Rd_i        = 5'd3;
      tick;
      tick;
      chk("mid_req", mem_req, 1);
      rst = 1'b0;
      tick;
      chk("mrst_req", mem_req, 0);
      chk("mrst_we", mem_we, 0);
      chk("mrst_addr", mem_addr, 0);
      chk("mrst_be", mem_be, 0);
      chk("mrst_wdata", mem_wdata, 0);
      chk("mrst_rw", RegWrite_o, 0);
      chk("mrst_data", WriteData_o, 0);
      chk("mrst_rd", Rd_o, 0);
      rst = 1'b1;
      drive_nop(1'b0, 32'h0, 5'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("stray_stall", stall_o, 0);
      tick;
      mem_ack = 1'b0;
      chk("stray_req", mem_req, 0);
      chk("stray_rw", RegWrite_o, 0);
      chk("stray_err", bus_err_o, 0);
      do_mem(6'h23, 1, 0, 1, 1, 32'h204, 32'h0, 5'd4, 2, 32'h1357_9BDF);

`ifdef MISALIGN_TRAP_EN
      do_mem(6'h23, 1, 0, 1, 1, 32'h101, 32'h0, 5'd6, 1, 32'h0);
`endif

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 9) < 3) begin
            do_nop(1'($urandom), $urandom, 5'($urandom));
         end else begin
            logic [5:0] op;
            logic       rd_en, wr_en;
            int         dly;
            op = ops[$urandom_range(0, 8)];
            if (op == 6'h28 || op == 6'h29 || op == 6'h2B) begin
               rd_en = 1'b0;
               wr_en = 1'b1;
            end else if (op == 6'h3F) begin
               rd_en = 1'($urandom);
               wr_en = ~rd_en | 1'($urandom);
            end else begin
               rd_en = 1'b1;
               wr_en = ($urandom_range(0, 7) == 0);
            end
            dly = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(1, 4);
            do_mem(op, rd_en, wr_en, 1'($urandom), 1'($urandom), $urandom,
                   $urandom, 5'($urandom), dly, $urandom);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
